// File: rtl/eq_gain_loader.sv
// Writer side of the equalizer gain vector: band writes land in a shadow bank, and a commit
// copies the whole bank into the active gains on the next frame-boundary strobe.
module eq_gain_loader #(
    parameter int unsigned                FILTER_NUM   = 8,
    parameter int unsigned                GAIN_BIT     = 32,
    parameter int unsigned                IDX_BIT      = 3,
    parameter logic signed [GAIN_BIT-1:0] DEFAULT_GAIN = 32'sh0001_0000,
    parameter int unsigned                TIMEOUT_CYC  = 64,
    parameter int unsigned                TMO_BIT      = 7
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic [IDX_BIT-1:0]             wr_idx,
    input  logic [GAIN_BIT-1:0]            wr_gain,
    input  logic                           clear_all,
    input  logic                           commit,
    input  logic                           calculated,
    output logic [GAIN_BIT*FILTER_NUM-1:0] gain,
    output logic                           shadow_dirty,
    output logic                           commit_pending,
    output logic                           apply_done,
    output logic                           apply_timeout,
    output logic                           err_idx
);

    typedef enum logic [0:0] {StIdle, StPending} state_e;

    state_e                                 state_q, state_d;
    logic [FILTER_NUM-1:0][GAIN_BIT-1:0]    shadow_q, shadow_d;
    logic [FILTER_NUM-1:0][GAIN_BIT-1:0]    active_q, active_d;
    logic                                   dirty_q, dirty_d;
    logic                                   done_q, done_d;
    logic                                   tmo_q, tmo_d;
    logic                                   err_q, err_d;
    logic [TMO_BIT-1:0]                     wdog_q, wdog_d;

    logic        wr_accept;
    logic        idx_ok;
    logic        wdog_expired;
    logic [31:0] idx_ext;

    assign wr_ready       = (state_q == StIdle);
    assign commit_pending = (state_q == StPending);
    assign wr_accept      = wr_valid && wr_ready;
    assign idx_ext        = 32'(wr_idx);
    assign idx_ok         = (idx_ext < FILTER_NUM);
    assign wdog_expired   = (wdog_q == TMO_BIT'(TIMEOUT_CYC - 1));

    assign gain          = active_q;
    assign shadow_dirty  = dirty_q;
    assign apply_done    = done_q;
    assign apply_timeout = tmo_q;
    assign err_idx       = err_q;

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        active_d = active_q;
        dirty_d  = dirty_q;
        done_d   = 1'b0;
        tmo_d    = 1'b0;
        err_d    = 1'b0;
        wdog_d   = wdog_q;

        unique case (state_q)
            StIdle: begin
                // Clear wins over a same-cycle write; the write is silently dropped.
                if (clear_all) begin
                    for (int i = 0; i < FILTER_NUM; i++) begin
                        shadow_d[i] = DEFAULT_GAIN;
                    end
                    dirty_d = 1'b1;
                end else if (wr_accept) begin
                    if (idx_ok) begin
                        for (int i = 0; i < FILTER_NUM; i++) begin
                            if (idx_ext == 32'(i)) begin
                                shadow_d[i] = wr_gain;
                            end
                        end
                        dirty_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (commit) begin
                    state_d = StPending;
                    wdog_d  = '0;
                end
            end
            StPending: begin
                // Shadow is frozen while pending, so the copy sees the committed set.
                if (calculated || wdog_expired) begin
                    active_d = shadow_q;
                    dirty_d  = 1'b0;
                    done_d   = 1'b1;
                    tmo_d    = ~calculated;
                    state_d  = StIdle;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            for (int i = 0; i < FILTER_NUM; i++) begin
                shadow_q[i] <= DEFAULT_GAIN;
                active_q[i] <= DEFAULT_GAIN;
            end
            dirty_q <= 1'b0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
            err_q   <= 1'b0;
            wdog_q  <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            dirty_q  <= dirty_d;
            done_q   <= done_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
            wdog_q   <= wdog_d;
        end
    end

endmodule

// File: tb/tb_eq_gain_loader.sv
// Bench for eq_gain_loader: an 8-band and a 6-band instance share one stimulus stream and are
// compared each cycle against a transaction-level model of shadow/active gain sets.
module tb_eq_gain_loader;

    localparam logic [31:0] DEF = 32'h0001_0000;
    localparam int          TMO = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic [2:0]  wr_idx = '0;
    logic [31:0] wr_gain = '0;
    logic        clear_all = 1'b0;
    logic        commit = 1'b0;
    logic        calculated = 1'b0;

    logic         wr_ready8, pend8, dirty8, done8, tmo8, err8;
    logic         wr_ready6, pend6, dirty6, done6, tmo6, err6;
    logic [255:0] gain8;
    logic [191:0] gain6;

    always #5 clk = ~clk;

    eq_gain_loader u_dut8 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready8), .wr_idx(wr_idx),
        .wr_gain(wr_gain), .clear_all(clear_all), .commit(commit), .calculated(calculated),
        .gain(gain8), .shadow_dirty(dirty8), .commit_pending(pend8), .apply_done(done8),
        .apply_timeout(tmo8), .err_idx(err8)
    );

    eq_gain_loader #(.FILTER_NUM(6)) u_dut6 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready6), .wr_idx(wr_idx),
        .wr_gain(wr_gain), .clear_all(clear_all), .commit(commit), .calculated(calculated),
        .gain(gain6), .shadow_dirty(dirty6), .commit_pending(pend6), .apply_done(done6),
        .apply_timeout(tmo6), .err_idx(err6)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int tag, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] at %0t: got %h, expected %h", name, tag, $time, act, exp);
        end
    endtask

    // Reference model: two gain sets per instance plus a commit in flight.
    int          nb [2] = '{8, 6};
    logic [31:0] sh [2][8];
    logic [31:0] ac [2][8];
    bit          m_dirty [2];
    bit          m_err [2];
    bit          m_pend, m_done, m_tmo, m_valid;
    int          m_len;

    initial begin
        m_valid = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                for (int d = 0; d < 2; d++) begin
                    for (int i = 0; i < 8; i++) begin
                        sh[d][i] = DEF;
                        ac[d][i] = DEF;
                    end
                    m_dirty[d] = 0;
                    m_err[d]   = 0;
                end
                m_pend = 0; m_done = 0; m_tmo = 0; m_len = 0; m_valid = 1;
            end else begin
                m_done = 0;
                m_tmo  = 0;
                for (int d = 0; d < 2; d++) m_err[d] = 0;
                if (!m_pend) begin
                    for (int d = 0; d < 2; d++) begin
                        if (clear_all) begin
                            for (int i = 0; i < 8; i++) sh[d][i] = DEF;
                            m_dirty[d] = 1;
                        end else if (wr_valid) begin
                            if (int'(wr_idx) < nb[d]) begin
                                sh[d][wr_idx] = wr_gain;
                                m_dirty[d] = 1;
                            end else begin
                                m_err[d] = 1;
                            end
                        end
                    end
                    if (commit) begin
                        m_pend = 1;
                        m_len  = 0;
                    end
                end else begin
                    m_len++;  // number of pending cycles completed, this one included
                    if (calculated || m_len == TMO) begin
                        for (int d = 0; d < 2; d++) begin
                            for (int i = 0; i < 8; i++) ac[d][i] = sh[d][i];
                            m_dirty[d] = 0;
                        end
                        m_done = 1;
                        m_tmo  = !calculated;
                        m_pend = 0;
                    end
                end
            end
        end
    end

    function automatic logic [31:0] dut_gain(input int d, input int i);
        if (d == 0) return gain8[32*i +: 32];
        return gain6[32*i +: 32];
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                for (int d = 0; d < 2; d++) begin
                    for (int i = 0; i < nb[d]; i++) chk("gain", 10*d + i, dut_gain(d, i), ac[d][i]);
                end
                chk("wr_ready8", 0, {31'b0, wr_ready8}, {31'b0, !m_pend});
                chk("wr_ready6", 0, {31'b0, wr_ready6}, {31'b0, !m_pend});
                chk("pending8", 0, {31'b0, pend8}, {31'b0, m_pend});
                chk("pending6", 0, {31'b0, pend6}, {31'b0, m_pend});
                chk("done8", 0, {31'b0, done8}, {31'b0, m_done});
                chk("done6", 0, {31'b0, done6}, {31'b0, m_done});
                chk("timeout8", 0, {31'b0, tmo8}, {31'b0, m_tmo});
                chk("timeout6", 0, {31'b0, tmo6}, {31'b0, m_tmo});
                chk("dirty8", 0, {31'b0, dirty8}, {31'b0, m_dirty[0]});
                chk("dirty6", 0, {31'b0, dirty6}, {31'b0, m_dirty[1]});
                chk("err8", 0, {31'b0, err8}, {31'b0, m_err[0]});
                chk("err6", 0, {31'b0, err6}, {31'b0, m_err[1]});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not reach the end, errors %0d", errors);
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        cyc(); cyc();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) chk("lit_reset_gain", i, gain8[32*i +: 32], 32'h0001_0000);
        chk("lit_reset_ready", 0, {31'b0, wr_ready8}, 32'd1);
        chk("lit_reset_flags", 0, {27'b0, pend8, dirty8, done8, tmo8, err8}, 32'd0);

        // Two writes, commit, strobe five cycles later.
        wr_valid = 1'b1; wr_idx = 3'd3; wr_gain = 32'h0002_0000; cyc();
        wr_idx = 3'd7; wr_gain = 32'hFFFF_8000; cyc();
        chk("lit_err6_idx7", 0, {31'b0, err6}, 32'd1);
        chk("lit_err8_idx7", 0, {31'b0, err8}, 32'd0);
        wr_valid = 1'b0; commit = 1'b1; cyc();
        commit = 1'b0;
        repeat (4) cyc();
        chk("lit_pre_strobe_b3", 0, gain8[127:96], 32'h0001_0000);
        calculated = 1'b1; cyc();
        calculated = 1'b0;
        chk("lit_b3", 0, gain8[127:96], 32'h0002_0000);
        chk("lit_b7", 0, gain8[255:224], 32'hFFFF_8000);
        chk("lit_b0", 0, gain8[31:0], 32'h0001_0000);
        chk("lit_apply_done", 0, {31'b0, done8}, 32'd1);
        chk("lit_dirty_cleared", 0, {31'b0, dirty8}, 32'd0);
        cyc();
        chk("lit_done_one_pulse", 0, {31'b0, done8}, 32'd0);

        // Commit with no strobe: watchdog forces the apply; held write waits for IDLE.
        commit = 1'b1; cyc();
        commit = 1'b0; wr_valid = 1'b1; wr_idx = 3'd1; wr_gain = 32'h1111_1111;
        n = 0;
        while (pend8 && n < 200) begin
            cyc();
            n++;
        end
        chk("lit_pending_len", 0, n, 32'd64);
        chk("lit_apply_timeout", 0, {31'b0, tmo8}, 32'd1);
        chk("lit_timeout_done", 0, {31'b0, done8}, 32'd1);
        cyc();
        wr_valid = 1'b0;
        chk("lit_held_write_taken", 0, {31'b0, dirty8}, 32'd1);

        // Strobe on the commit edge does not count.
        commit = 1'b1; calculated = 1'b1; cyc();
        commit = 1'b0; calculated = 1'b0;
        chk("lit_coincident_strobe", 0, {31'b0, pend8}, 32'd1);
        cyc(); cyc();
        calculated = 1'b1; cyc();
        calculated = 1'b0;
        chk("lit_second_strobe_done", 0, {31'b0, done8}, 32'd1);
        chk("lit_second_strobe_tmo", 0, {31'b0, tmo8}, 32'd0);
        chk("lit_b1", 0, gain8[63:32], 32'h1111_1111);

        // Write and commit in the same cycle.
        wr_valid = 1'b1; wr_idx = 3'd0; wr_gain = 32'd5; commit = 1'b1; cyc();
        wr_valid = 1'b0; commit = 1'b0; calculated = 1'b1; cyc();
        calculated = 1'b0;
        chk("lit_same_cycle_b0", 0, gain8[31:0], 32'd5);

        // Clear beats a same-cycle write.
        clear_all = 1'b1; wr_valid = 1'b1; wr_idx = 3'd2; wr_gain = 32'd9; cyc();
        clear_all = 1'b0; wr_valid = 1'b0; commit = 1'b1; cyc();
        commit = 1'b0; calculated = 1'b1; cyc();
        calculated = 1'b0;
        chk("lit_clear_b2", 0, gain8[95:64], 32'h0001_0000);
        chk("lit_clear_b0", 0, gain8[31:0], 32'h0001_0000);

        // Reset in the middle of a pending commit.
        wr_valid = 1'b1; wr_idx = 3'd4; wr_gain = 32'h1234_5678; cyc();
        wr_valid = 1'b0; commit = 1'b1; cyc();
        commit = 1'b0;
        repeat (3) cyc();
        rst = 1'b1; cyc();
        rst = 1'b0;
        chk("lit_rst_pending", 0, {31'b0, pend8}, 32'd0);
        chk("lit_rst_b4", 0, gain8[159:128], 32'h0001_0000);
        cyc();
        chk("lit_rst_no_done", 0, {31'b0, done8}, 32'd0);

        // Random traffic: frequent strobes first, then rare strobes to exercise the watchdog.
        for (int k = 0; k < 3000; k++) begin
            rst        = ($urandom_range(0, 399) == 0);
            wr_valid   = $urandom_range(0, 1) == 1;
            wr_idx     = 3'($urandom_range(0, 7));
            wr_gain    = $urandom;
            clear_all  = ($urandom_range(0, 99) < 4);
            commit     = ($urandom_range(0, 99) < 10);
            calculated = ($urandom_range(0, 99) < ((k < 1500) ? 20 : 1));
            cyc();
        end
        rst = 1'b0; wr_valid = 1'b0; clear_all = 1'b0; commit = 1'b0; calculated = 1'b0;
        repeat (3) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
